// File: rtl/fifo_pkg.sv
// Shared FIFO widths, depth and state type for the input/output control blocks.
// FIFO_IN_PARITY_EN widens the storage word with an even-parity bit.
package fifo_pkg;

  localparam int DATA_W     = 8;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = 6;
  localparam int FIFO_DEPTH = 32;

`ifdef FIFO_IN_PARITY_EN
  localparam int WR_W = DATA_W + 1;

  function automatic logic even_par(
    input logic [DATA_W-1:0] d
  );
    return ^d;
  endfunction
`else
  localparam int WR_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } fifo_state_t;

endpackage

// File: rtl/fifo_input_control_if.sv
// Producer-to-storage write bundle of the FIFO input side.
// Word width follows FIFO_IN_PARITY_EN through fifo_pkg.
interface fifo_input_control_if;
  import fifo_pkg::*;

  logic              write_en;
  logic [DATA_W-1:0] data_in;
  logic              write_en_o;
  logic [PTR_W-1:0]  wr_ptr;
  logic [WR_W-1:0]   wr_data_o;

  modport master (
    output write_en,
    output data_in,
    input  write_en_o,
    input  wr_ptr,
    input  wr_data_o
  );

  modport slave (
    input  write_en,
    input  data_in,
    output write_en_o,
    output wr_ptr,
    output wr_data_o
  );

endinterface

// File: rtl/fifo_occupancy_counter.sv
// Occupancy register with full/almost_full/empty flags.
// A decrement at zero occupancy is ignored.
module fifo_occupancy_counter
  import fifo_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_THRESH = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             full,
  output logic             almost_full,
  output logic             empty
);

  logic dec_ok;

  assign dec_ok = dec && (count != '0);

  always_comb begin
    count_next = count;
    unique case (1'b1)
      (inc && !dec_ok): count_next = count + 1'b1;
      (dec_ok && !inc): count_next = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(AF_THRESH));

endmodule

// File: rtl/fifo_input_control.sv
// FIFO write-side control: admission, write pointer, storage strobe, state.
// FIFO_IN_PARITY_EN appends even parity as bit 8 of wr_data_o.
module fifo_input_control
  import fifo_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_THRESH = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_input_control_if.slave  bus,
  input  logic                 rd_pop,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 almost_full,
  output logic                 empty,
  output logic                 overflow
);

  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count_next;
  logic [WR_W-1:0]  word;
  logic             accept;
  fifo_state_t      state;

  // Admission uses the pre-edge count; a same-cycle pop cannot free a slot.
  assign accept = bus.write_en && !full;

`ifdef FIFO_IN_PARITY_EN
  assign word = {even_par(bus.data_in), bus.data_in};
`else
  assign word = bus.data_in;
`endif

  fifo_occupancy_counter #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_occ (
    .clk         (clk),
    .reset       (reset),
    .inc         (accept),
    .dec         (rd_pop),
    .count       (count),
    .count_next  (count_next),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr            <= '0;
      bus.write_en_o <= 1'b0;
      bus.wr_ptr     <= '0;
      bus.wr_data_o  <= '0;
      overflow       <= 1'b0;
      state          <= EMPTY;
    end else begin
      bus.write_en_o <= accept;
      overflow       <= bus.write_en && !accept;
      if (accept) begin
        bus.wr_ptr    <= ptr;
        bus.wr_data_o <= word;
        ptr           <= (ptr + 1'b1) & PTR_MASK;
      end
      unique case (state)
        EMPTY: begin
          if (accept) state <= FILLING;
        end
        FILLING: begin
          if (count_next == CNT_W'(DEPTH))
            state <= FULL;
          else if (count_next == '0)
            state <= EMPTY;
        end
        FULL: begin
          if (rd_pop) state <= FILLING;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_input_control.sv
// Bench for fifo_input_control: occupancy model checked every cycle
// plus directed scenarios with literal expectations.
module tb_fifo_input_control;
  import fifo_pkg::*;

  localparam int DEPTH = 32;
  localparam int AF    = 28;

  logic             clk;
  logic             reset;
  logic             rd_pop;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             almost_full;
  logic             empty;
  logic             overflow;

  fifo_input_control_if bus ();

  fifo_input_control #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .rd_pop      (rd_pop),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int m_count = 0;
  int m_ptr   = 0;
  int e_we    = 0;
  int e_wptr  = 0;
  int e_wdata = 0;
  int e_ovf   = 0;

  function automatic int exp_word(input logic [7:0] d);
`ifdef FIFO_IN_PARITY_EN
    return int'({^d, d});
`else
    return int'(d);
`endif
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: occupancy and pointer from the admission rules.
  initial begin
    int acc;
    int pop;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_count = 0; m_ptr = 0; e_we = 0;
        e_wptr = 0; e_wdata = 0; e_ovf = 0;
      end else begin
        acc = (bus.write_en && m_count < DEPTH) ? 1 : 0;
        pop = (rd_pop && m_count > 0) ? 1 : 0;
        e_we  = acc;
        e_ovf = (bus.write_en && acc == 0) ? 1 : 0;
        if (acc == 1) begin
          e_wptr  = m_ptr;
          e_wdata = exp_word(bus.data_in);
          m_ptr   = (m_ptr + 1) % DEPTH;
        end
        m_count = m_count + acc - pop;
      end
    end
  end

  function automatic int exp_state();
    if (m_count == 0)     return int'(EMPTY);
    if (m_count == DEPTH) return int'(FULL);
    return int'(FILLING);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("count", int'(count), m_count);
        check("full", int'(full), (m_count == DEPTH) ? 1 : 0);
        check("empty", int'(empty), (m_count == 0) ? 1 : 0);
        check("almost_full", int'(almost_full), (m_count >= AF) ? 1 : 0);
        check("overflow", int'(overflow), e_ovf);
        check("write_en_o", int'(bus.write_en_o), e_we);
        check("wr_ptr", int'(bus.wr_ptr), e_wptr);
        check("wr_data_o", int'(bus.wr_data_o), e_wdata);
        check("state", int'(dut.state), exp_state());
      end
    end
  end

  task automatic step(input logic we, input logic [7:0] d, input logic pop);
    bus.write_en = we;
    bus.data_in  = d;
    rd_pop       = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.write_en = 1'b0;
    bus.data_in  = 8'h00;
    rd_pop       = 1'b0;
    do_reset();
    chk_en = 1'b1;

    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_we", int'(bus.write_en_o), 0);

    // Three writes land at addresses 0,1,2.
    step(1'b1, 8'h11, 1'b0);
    check("s1_we", int'(bus.write_en_o), 1);
    check("s1_ptr0", int'(bus.wr_ptr), 0);
    check("s1_d0", int'(bus.wr_data_o), exp_word(8'h11));
    step(1'b1, 8'h22, 1'b0);
    check("s1_ptr1", int'(bus.wr_ptr), 1);
    step(1'b1, 8'h33, 1'b0);
    check("s1_ptr2", int'(bus.wr_ptr), 2);
    check("s1_count", int'(count), 3);
    check("s1_empty", int'(empty), 0);
    step(1'b0, 8'h44, 1'b0);
    check("s1_idle_we", int'(bus.write_en_o), 0);
    check("s1_hold_ptr", int'(bus.wr_ptr), 2);

    // Fill to the top, then overflow.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 8'(i + 8'h40), 1'b0);
      if (i == 26) check("s2_af_27", int'(almost_full), 0);
      if (i == 27) check("s2_af_28", int'(almost_full), 1);
      if (i == 30) check("s2_full_31", int'(full), 0);
    end
    check("s2_full", int'(full), 1);
    check("s2_state", int'(dut.state), int'(FULL));
    check("s2_ptr31", int'(bus.wr_ptr), 31);
    step(1'b1, 8'hEE, 1'b0);
    check("s2_ovf", int'(overflow), 1);
    check("s2_ovf_we", int'(bus.write_en_o), 0);
    check("s2_ovf_cnt", int'(count), 32);
    step(1'b0, 8'h00, 1'b0);
    check("s2_ovf_once", int'(overflow), 0);

    // Write and pop together at full: write rejected.
    step(1'b1, 8'hAB, 1'b1);
    check("s3_ovf", int'(overflow), 1);
    check("s3_count", int'(count), 31);
    check("s3_state", int'(dut.state), int'(FILLING));
    check("s3_we", int'(bus.write_en_o), 0);

    // Write and pop together at count 5.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 1'b0);
    check("s4_cnt5", int'(count), 5);
    step(1'b1, 8'hAA, 1'b1);
    check("s4_cnt", int'(count), 5);
    check("s4_we", int'(bus.write_en_o), 1);
    check("s4_ptr", int'(bus.wr_ptr), 5);
    step(1'b1, 8'hBB, 1'b0);
    check("s4_ptr_next", int'(bus.wr_ptr), 6);

    // Pointer wrap with interleaved pops, then pop at empty.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), logic'(i % 2));
      if (i == 31) check("s5_ptr31", int'(bus.wr_ptr), 31);
      if (i == 32) check("s5_wrap", int'(bus.wr_ptr), 0);
    end
    check("s5_cnt20", int'(count), 20);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
    check("s5_drained", int'(count), 0);
    step(1'b0, 8'h00, 1'b1);
    check("s5_pop_empty", int'(count), 0);
    check("s5_empty", int'(empty), 1);

    // Reset mid-stream discards a write in flight.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 8'(i + 1), 1'b0);
    check("s6_cnt12", int'(count), 12);
    reset = 1'b1;
    step(1'b1, 8'h5A, 1'b1);
    reset = 1'b0;
    check("s6_count", int'(count), 0);
    check("s6_empty", int'(empty), 1);
    check("s6_ptr", int'(bus.wr_ptr), 0);
    check("s6_we", int'(bus.write_en_o), 0);
    step(1'b1, 8'h07, 1'b0);
`ifdef FIFO_IN_PARITY_EN
    check("s6_parity", int'(bus.wr_data_o), 32'h107);
`else
    check("s6_data", int'(bus.wr_data_o), 32'h07);
`endif
    step(1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_input_control.md
FIFO_INPUT_CONTROL -- requirements
Module: fifo_input_control

Interface
REQ-001 SHALL have parameter DEPTH, default 32: FIFO entries; power of two.
REQ-002 SHALL have parameter AF_THRESH, default 28: occupancy at or above which almost_full asserts.
REQ-003 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port write_en, input, 1: producer write request, sampled each cycle.
REQ-006 SHALL have port data_in, input, 8: producer write data.
REQ-007 SHALL have port rd_pop, input, 1: one-cycle pulse from the read side per word removed.
REQ-008 SHALL have port write_en_o, output, 1: registered storage write strobe.
REQ-009 SHALL have port wr_ptr, output, 5: storage address for the current write_en_o.
REQ-010 SHALL have port wr_data_o, output, 8 (9 with parity): registered data to storage.
REQ-011 SHALL have port count, output, 6: occupancy, 0..DEPTH.
REQ-012 SHALL have ports full, almost_full, empty, output, 1 each: occupancy flags.
REQ-013 SHALL have port overflow, output, 1: one-cycle pulse per rejected write.

Function
REQ-014 SHALL accept a write when write_en=1 and count<DEPTH, judged on the pre-edge count.
REQ-015 SHALL, one cycle after acceptance, assert write_en_o=1 with wr_data_o=data_in and wr_ptr=address before increment.
REQ-016 SHALL increment the internal pointer modulo DEPTH per accepted write; 31 wraps to 0.
REQ-017 SHALL hold write_en_o=0 in cycles with no accepted write; wr_ptr and wr_data_o hold their last value.
REQ-018 SHALL reject write_en when count=DEPTH, even if rd_pop is set that cycle; overflow=1 next cycle, pointer and count unchanged except for the pop.
REQ-019 SHALL update count as follows: +1 on accept only; -1 on rd_pop only; unchanged on both; rd_pop with count=0 ignored.
REQ-020 SHALL derive full=(count==DEPTH), empty=(count==0) and almost_full=(count>=AF_THRESH) from the registered count.
REQ-021 SHALL run a state machine with states EMPTY, FILLING and FULL.
REQ-022 SHALL transition EMPTY->FILLING on accept, FILLING->FULL when the next count equals DEPTH, FULL->FILLING on rd_pop, and FILLING->EMPTY when the next count equals 0.
REQ-023 SHALL make the flags consistent with the state: full=1 only in FULL and empty=1 only in EMPTY.

Reset
REQ-024 SHALL, when reset=1 at a clock edge, clear the pointer, count, write_en_o, wr_ptr, wr_data_o, full, almost_full and overflow to 0, set empty=1 and set state=EMPTY.
REQ-025 SHALL let reset override write_en and rd_pop in the same cycle; a write in flight is discarded.

Configuration
REQ-026 SHALL, with FIFO_IN_PARITY_EN defined, widen wr_data_o to 9 bits, with bit 8 the even parity of data_in (XOR of its bits).
REQ-027 SHALL, without FIFO_IN_PARITY_EN, make wr_data_o 8 bits and include no parity logic.

Structure
REQ-028 SHALL take DATA_W=8, PTR_W=5, CNT_W=6, the default DEPTH and the state typedef (EMPTY/FILLING/FULL) from shared package fifo_pkg, also used by fifo_output_control.
REQ-029 SHALL implement count and the flags in sub-module fifo_occupancy_counter (inputs inc, dec; outputs count and flags).

Verification
REQ-030 SHALL cover: reset, then write_en with data_in=0x11, 0x22, 0x33 -> write_en_o pulses with wr_ptr 0,1,2; count=3; empty=0.
REQ-031 SHALL cover: 32 consecutive writes -> almost_full=1 when count reaches 28; full=1 and state FULL when count reaches 32; 33rd write -> overflow pulses once with no write_en_o.
REQ-032 SHALL cover: at full, write_en and rd_pop in the same cycle -> write rejected, overflow=1, count=31, state FILLING.
REQ-033 SHALL cover: count=5, write_en and rd_pop in the same cycle -> count stays 5; write_en_o=1; pointer advances by 1.
REQ-034 SHALL cover: 40 writes interleaved with pops -> wr_ptr wraps 31->0; rd_pop at count=0 leaves count=0.
REQ-035 SHALL cover: reset asserted mid-stream at count=12 -> next cycle count=0, empty=1, wr_ptr=0, write_en_o=0; with FIFO_IN_PARITY_EN, data_in=0x07 -> wr_data_o=0x107.
